// File: rtl/vga_cell_capture_if.sv
// Video stream into the cell-capture monitor and the captured-grid results coming back out.
interface vga_cell_capture_if #(
    parameter int unsigned COLS = 40,
    parameter int unsigned ROWS = 30
);
    logic                 pix_en;
    logic                 hsync;
    logic                 vsync;
    logic [3:0]           r_in;
    logic [3:0]           g_in;
    logic [3:0]           b_in;
    logic [COLS*ROWS-1:0] frame_state;
    logic [11:0]          alive_count;
    logic                 frame_valid;
    logic                 locked;
    logic                 h_err;
    logic                 v_err;

    modport master (
        output pix_en, hsync, vsync, r_in, g_in, b_in,
        input  frame_state, alive_count, frame_valid, locked, h_err, v_err
    );

    modport slave (
        input  pix_en, hsync, vsync, r_in, g_in, b_in,
        output frame_state, alive_count, frame_valid, locked, h_err, v_err
    );
endinterface

// File: rtl/vga_cell_capture.sv
// Receive-side VGA monitor: recovers raster position from the syncs, samples every cell centre
// and publishes the captured life grid plus its alive count once per frame.
module vga_cell_capture #(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned H_START = 144,
    parameter int unsigned V_START = 35,
    parameter int unsigned CELL    = 16,
    parameter int unsigned COLS    = 40,
    parameter int unsigned ROWS    = 30
) (
    input logic               clk,
    input logic               rst,
    vga_cell_capture_if.slave vid
);
    localparam int unsigned Cells  = COLS * ROWS;
    localparam int unsigned IdxW   = $clog2(Cells);
    localparam logic [9:0]  HStart = 10'(H_START);
    localparam logic [9:0]  HEnd   = 10'(H_START + COLS * CELL);
    localparam logic [9:0]  VStart = 10'(V_START);
    localparam logic [9:0]  VEnd   = 10'(V_START + ROWS * CELL);
    localparam logic [9:0]  HLast  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  VLast  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  CellW  = 10'(CELL);
    localparam logic [9:0]  Half   = 10'(CELL / 2);
    localparam logic [9:0]  CntMax = 10'h3ff;

    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic [Cells-1:0] work_q, work_d;
    logic [11:0]      count_q, count_d;
    logic [Cells-1:0] state_q, state_d;
    logic [11:0]      alive_q, alive_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             h_armed_q, h_armed_d;
    logic             h_err_q, h_err_d;
    logic             v_err_q, v_err_d;

    logic            hs_fall;
    logic            vs_fall;
    logic            in_x;
    logic            in_y;
    logic            sample;
    logic            alive;
    logic            commit;
    logic [9:0]      px;
    logic [9:0]      py;
    logic [9:0]      cell_x;
    logic [9:0]      cell_y;
    logic [IdxW-1:0] cell_idx;

    assign hs_fall = vid.pix_en & hs_q & ~vid.hsync;
    assign vs_fall = vid.pix_en & vs_q & ~vid.vsync;

    assign px     = h_q - HStart;
    assign py     = v_q - VStart;
    assign in_x   = (h_q >= HStart) && (h_q < HEnd);
    assign in_y   = (v_q >= VStart) && (v_q < VEnd);
    assign sample = vid.pix_en && in_x && in_y && ((px % CellW) == Half) && ((py % CellW) == Half);
    assign cell_x = px / CellW;
    assign cell_y = py / CellW;
    assign cell_idx = IdxW'(32'(cell_y) * COLS + 32'(cell_x));
    assign alive  = |(vid.r_in | vid.g_in | vid.b_in);

    // The hsync edge that moves v onto the first line below the grid closes the frame; a
    // coincident vsync edge resets v instead, so it never commits.
    assign commit = hs_fall & ~vs_fall & locked_q & (v_q == VEnd - 10'd1);

    always_comb begin
        hs_d      = hs_q;
        vs_d      = vs_q;
        h_d       = h_q;
        v_d       = v_q;
        work_d    = work_q;
        count_d   = count_q;
        state_d   = state_q;
        alive_d   = alive_q;
        valid_d   = commit;
        locked_d  = locked_q;
        h_armed_d = h_armed_q;
        h_err_d   = h_err_q;
        v_err_d   = v_err_q;

        if (vid.pix_en) begin
            hs_d = vid.hsync;
            vs_d = vid.vsync;

            if (hs_fall) begin
                h_d = '0;
            end else if (h_q != CntMax) begin
                h_d = h_q + 10'd1;
            end

            if (vs_fall) begin
                v_d = '0;
            end else if (hs_fall && (v_q != CntMax)) begin
                v_d = v_q + 10'd1;
            end

            if (sample) begin
                work_d[cell_idx] = alive;
            end

            if (vs_fall) begin
                count_d = '0;
            end else if (sample && alive) begin
                count_d = count_q + 12'd1;
            end
        end

        if (commit) begin
            state_d = work_q;
            alive_d = count_q;
        end

        // A line is only measured if it began at or after lock, so the edge that starts the
        // first locked line arms the check rather than being checked itself.
        if (hs_fall) begin
            if (locked_q && h_armed_q && (h_q != HLast)) begin
                h_err_d = 1'b1;
            end
            h_armed_d = locked_q | vs_fall;
        end

        if (vs_fall) begin
            if (locked_q && (v_q != VLast)) begin
                v_err_d = 1'b1;
            end
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            h_q       <= '0;
            v_q       <= '0;
            work_q    <= '0;
            count_q   <= '0;
            state_q   <= '0;
            alive_q   <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            h_armed_q <= 1'b0;
            h_err_q   <= 1'b0;
            v_err_q   <= 1'b0;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            h_q       <= h_d;
            v_q       <= v_d;
            work_q    <= work_d;
            count_q   <= count_d;
            state_q   <= state_d;
            alive_q   <= alive_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            h_armed_q <= h_armed_d;
            h_err_q   <= h_err_d;
            v_err_q   <= v_err_d;
        end
    end

    assign vid.frame_state = state_q;
    assign vid.alive_count = alive_q;
    assign vid.frame_valid = valid_q;
    assign vid.locked      = locked_q;
    assign vid.h_err       = h_err_q;
    assign vid.v_err       = v_err_q;
endmodule
